// File: rtl/mcac_pkg.sv
// Shared constants for the multi-channel ADPCM codec TDM path.
// Used by the TDMO serializer and the frame buffer that feeds it.
//   NUM_CHAN   : channels per TDM frame
//   CHAN_W     : channel index width
//   IDLE_CODE  : word presented for a channel with no data this frame
//   chan_t     : channel index type
//   fb_state_t : frame buffer control states
package mcac_pkg;

  localparam int         NUM_CHAN  = 32;
  localparam int         CHAN_W    = 5;
  localparam logic [7:0] IDLE_CODE = 8'hFF;

  typedef logic [CHAN_W-1:0] chan_t;

  // WAIT_FS: no completed frame exists yet, reads give the idle code.
  // RUN:     normal ping-pong operation until the next reset.
  typedef enum logic {
    ST_WAIT_FS = 1'b0,
    ST_RUN     = 1'b1
  } fb_state_t;

endpackage

// File: rtl/tdmo_bank.sv
// One bank of the TDMO ping-pong buffer: NUM_CHAN x 8-bit words, each with
// a valid bit.
//   clk, reset : clock, asynchronous active-low reset (clears valid bits)
//   wr_en      : store wr_data at wr_chan and mark it valid
//   wr_chan    : write channel (indices >= NUM_CHAN are ignored)
//   wr_data    : word to store
//   clr        : clear every valid bit (data words are kept)
//   rd_chan    : combinational read channel
//   rd_data    : stored word for rd_chan
//   rd_hit     : rd_chan is in range and its valid bit is set
//   valid      : all valid bits, for popcount and duplicate detection
module tdmo_bank #(
  parameter int NUM_CHAN = 32,
  parameter int CHAN_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CHAN_W-1:0]   wr_chan,
  input  logic [7:0]          wr_data,
  input  logic                clr,
  input  logic [CHAN_W-1:0]   rd_chan,
  output logic [7:0]          rd_data,
  output logic                rd_hit,
  output logic [NUM_CHAN-1:0] valid
);

  logic [7:0] data [NUM_CHAN];
  logic       rd_in_range;

  generate
    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      logic [7:0] word;
      logic       vld;
      logic       sel;

      assign sel = wr_en && (wr_chan == CHAN_W'(gi));

      // Data words carry no reset; only the valid bit decides readability.
      always_ff @(posedge clk) begin
        if (sel) begin
          word <= wr_data;
        end
      end

      // Clear wins over write, although the top never issues both at once.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld <= 1'b0;
        end else if (clr) begin
          vld <= 1'b0;
        end else if (sel) begin
          vld <= 1'b1;
        end
      end

      assign data[gi]  = word;
      assign valid[gi] = vld;
    end
  endgenerate

  assign rd_in_range = ({1'b0, rd_chan} < (CHAN_W+1)'(NUM_CHAN));
  assign rd_data     = rd_in_range ? data[rd_chan] : 8'h00;
  assign rd_hit      = rd_in_range && valid[rd_chan];

endmodule

// File: rtl/tdmo_frame_buffer.sv
// Ping-pong channel buffer in front of the TDM output serializer.
// Frame N is written into bank[wsel] while TDMO reads frame N-1 from
// bank[!wsel]; the banks swap on each frame-sync pulse.
//   clk, reset : clock, asynchronous active-low reset
//   fs         : one-cycle frame-sync pulse, swaps banks
//   wr_valid / wr_ready / wr_chan / wr_data : encoder write handshake
//   rd_en / rd_chan                         : TDMO read request
//   rd_valid / rd_data                      : registered read response
//   miss_cnt   : channels left unwritten in the last completed frame
//   dup_err    : one-cycle pulse after a channel is written twice in a frame
module tdmo_frame_buffer #(
  parameter int         NUM_CHAN  = mcac_pkg::NUM_CHAN,
  parameter int         CHAN_W    = mcac_pkg::CHAN_W,
  parameter logic [7:0] IDLE_CODE = mcac_pkg::IDLE_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAN_W-1:0] wr_chan,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [CHAN_W-1:0] rd_chan,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [CHAN_W:0]   miss_cnt,
  output logic              dup_err
);

  import mcac_pkg::fb_state_t;
  import mcac_pkg::ST_WAIT_FS;
  import mcac_pkg::ST_RUN;

  fb_state_t state;
  fb_state_t state_next;

  logic                wsel;
  logic                xfer;
  logic                wr_in_range;
  logic                dup_hit;
  logic [1:0]          bank_we;
  logic [1:0]          bank_clr;
  logic [7:0]          bank_rd_data [2];
  logic [1:0]          bank_rd_hit;
  logic [NUM_CHAN-1:0] bank_valid [2];
  logic [NUM_CHAN-1:0] wvalid;
  logic [CHAN_W:0]     filled;
  logic [7:0]          read_word;

  // Writes are refused in the fs cycle so a write never lands on a bank
  // whose valid bits are being cleared by the swap.
  assign wr_ready    = reset && !fs;
  assign xfer        = wr_valid && wr_ready;
  assign wr_in_range = ({1'b0, wr_chan} < (CHAN_W+1)'(NUM_CHAN));

  always_comb begin
    bank_we  = 2'b00;
    bank_clr = 2'b00;
    bank_we[wsel]   = xfer;
    // The current read bank becomes the write bank after the swap.
    bank_clr[!wsel] = fs;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      tdmo_bank #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
      ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bank_we[gi]),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .clr     (bank_clr[gi]),
        .rd_chan (rd_chan),
        .rd_data (bank_rd_data[gi]),
        .rd_hit  (bank_rd_hit[gi]),
        .valid   (bank_valid[gi])
      );
    end
  endgenerate

  assign wvalid  = bank_valid[wsel];
  assign dup_hit = xfer && wr_in_range && wvalid[wr_chan];

  always_comb begin
    filled = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      filled = filled + {{CHAN_W{1'b0}}, wvalid[i]};
    end
  end

  // Before the first completed frame nothing is readable; afterwards the
  // read bank is the one not being written, and the read in an fs cycle
  // still sees the frame being finished since wsel has not toggled yet.
  always_comb begin
    read_word = IDLE_CODE;
    if (state == ST_RUN && bank_rd_hit[!wsel]) begin
      read_word = bank_rd_data[!wsel];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT_FS: if (fs) state_next = ST_RUN;
      ST_RUN:     state_next = ST_RUN;
      default:    state_next = ST_WAIT_FS;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_WAIT_FS;
      wsel     <= 1'b0;
      miss_cnt <= '0;
      dup_err  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= IDLE_CODE;
    end else begin
      state    <= state_next;
      dup_err  <= dup_hit;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= read_word;
      end
      if (fs) begin
        wsel     <= !wsel;
        miss_cnt <= (CHAN_W+1)'(NUM_CHAN) - filled;
      end
    end
  end

endmodule
